// File: rtl/dds_wave_generator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_wave_generator_pkg : waveform encodings and parameter helpers for the DDS
// Revision 1.0
// ----------------------------------------------------------------------------
package dds_wave_generator_pkg;

  localparam logic [2:0] WAVE_SQUARE   = 3'd0;
  localparam logic [2:0] WAVE_SAW_UP   = 3'd1;
  localparam logic [2:0] WAVE_SAW_DN   = 3'd2;
  localparam logic [2:0] WAVE_TRIANGLE = 3'd3;
  localparam logic [2:0] WAVE_SINE     = 3'd4;

  // Mid-scale threshold gives a 50% square after reset.
  function automatic int unsigned reset_duty(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  function automatic bit params_ok(input int acc_w, input int freq_w,
                                   input int addr_w, input int data_w);
    return (data_w > 0) && (freq_w > 0) && (freq_w <= acc_w) &&
           (addr_w >= data_w + 1) && (addr_w <= acc_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_wave_generator_phase_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_phase_acc : phase accumulator with carry pulse and double-buffered settings
// Revision 1.0
// ----------------------------------------------------------------------------
module dds_phase_acc
  import dds_wave_generator_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int FREQ_W = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enb_i,
  input  logic              init_i,
  input  logic              load_i,
  input  logic [FREQ_W-1:0] freq_word_i,
  input  logic [2:0]        wave_sel_i,
  input  logic [DATA_W-1:0] duty_i,
  output logic [ADDR_W-1:0] phase_o,
  output logic              co_o,
  output logic              load_ack_o,
  output logic [2:0]        wave_o,
  output logic [DATA_W-1:0] duty_o
);

  localparam logic [DATA_W-1:0] DUTY_RST = DATA_W'(reset_duty(DATA_W));

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              co_q, co_d;
  logic              ack_q, ack_d;
  logic              pend_q, pend_d;
  logic [FREQ_W-1:0] act_freq_q, act_freq_d, pend_freq_q, pend_freq_d;
  logic [2:0]        act_wave_q, act_wave_d, pend_wave_q, pend_wave_d;
  logic [DATA_W-1:0] act_duty_q, act_duty_d, pend_duty_q, pend_duty_d;
  logic [ACC_W:0]    sum;
  logic              wrap;
  logic              apply;

  always_comb begin
    sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(act_freq_q);
    wrap  = enb_i && !init_i && sum[ACC_W];
    apply = pend_q && (wrap || !enb_i || (act_freq_q == '0) || init_i);

    acc_d       = acc_q;
    co_d        = co_q;
    ack_d       = apply;
    pend_d      = pend_q;
    act_freq_d  = act_freq_q;
    act_wave_d  = act_wave_q;
    act_duty_d  = act_duty_q;
    pend_freq_d = pend_freq_q;
    pend_wave_d = pend_wave_q;
    pend_duty_d = pend_duty_q;

    if (init_i) begin
      acc_d = '0;
      co_d  = 1'b0;
    end else if (enb_i) begin
      acc_d = sum[ACC_W-1:0];
      co_d  = sum[ACC_W];
    end

    if (apply) begin
      act_freq_d = pend_freq_q;
      act_wave_d = pend_wave_q;
      act_duty_d = pend_duty_q;
      pend_d     = 1'b0;
    end
    // A LOAD coinciding with an apply becomes the next pending set.
    if (load_i) begin
      pend_freq_d = freq_word_i;
      pend_wave_d = wave_sel_i;
      pend_duty_d = duty_i;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      co_q        <= 1'b0;
      ack_q       <= 1'b0;
      pend_q      <= 1'b0;
      act_freq_q  <= '0;
      act_wave_q  <= WAVE_SQUARE;
      act_duty_q  <= DUTY_RST;
      pend_freq_q <= '0;
      pend_wave_q <= WAVE_SQUARE;
      pend_duty_q <= DUTY_RST;
    end else begin
      acc_q       <= acc_d;
      co_q        <= co_d;
      ack_q       <= ack_d;
      pend_q      <= pend_d;
      act_freq_q  <= act_freq_d;
      act_wave_q  <= act_wave_d;
      act_duty_q  <= act_duty_d;
      pend_freq_q <= pend_freq_d;
      pend_wave_q <= pend_wave_d;
      pend_duty_q <= pend_duty_d;
    end
  end

  // The carry flag freezes with the accumulator; gating keeps CO low while paused.
  assign co_o       = co_q && enb_i;
  assign load_ack_o = ack_q;
  assign phase_o    = acc_q[ACC_W-1 -: ADDR_W];
  assign wave_o     = act_wave_q;
  assign duty_o     = act_duty_q;

endmodule
`default_nettype wire

// File: rtl/dds_wave_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_wave_generator : DDS waveform generator with two-stage sample shaper
// Revision 1.0
// ----------------------------------------------------------------------------
module dds_wave_generator
  import dds_wave_generator_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int FREQ_W = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENB,
  input  logic              INIT,
  input  logic [FREQ_W-1:0] FREQ_WORD,
  input  logic [2:0]        WAVE_SEL,
  input  logic [DATA_W-1:0] DUTY,
  input  logic              LOAD,
  output logic              LOAD_ACK,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [DATA_W-1:0] ROM_DATA,
  output logic              CO,
  output logic [DATA_W-1:0] OUTPUTWAVE,
  output logic              VALID
);

  if (!params_ok(ACC_W, FREQ_W, ADDR_W, DATA_W)) begin : g_bad_params
    $error("dds_wave_generator: illegal width parameters");
  end

  logic [ADDR_W-1:0] phase;
  logic [2:0]        act_wave;
  logic [DATA_W-1:0] act_duty;

  dds_phase_acc #(
    .ACC_W (ACC_W),
    .FREQ_W(FREQ_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_phase_acc (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .enb_i      (ENB),
    .init_i     (INIT),
    .load_i     (LOAD),
    .freq_word_i(FREQ_WORD),
    .wave_sel_i (WAVE_SEL),
    .duty_i     (DUTY),
    .phase_o    (phase),
    .co_o       (CO),
    .load_ack_o (LOAD_ACK),
    .wave_o     (act_wave),
    .duty_o     (act_duty)
  );

  // Only the top DATA_W+1 phase bits feed the shaper; ROM gets the full phase.
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W:0]   ph1_q;
  logic [2:0]        wave1_q;
  logic [DATA_W-1:0] duty1_q;
  logic              vld1_q;
  logic [DATA_W-1:0] out_q;
  logic              vld2_q;

  logic [DATA_W-1:0] s_val;
  logic [DATA_W-1:0] t_val;
  logic [DATA_W-1:0] sample_d;

  always_comb begin
    s_val    = ph1_q[DATA_W -: DATA_W];
    t_val    = ph1_q[DATA_W-1:0];
    sample_d = '0;
    case (wave1_q)
      WAVE_SQUARE:   sample_d = (s_val < duty1_q) ? '1 : '0;
      WAVE_SAW_UP:   sample_d = s_val;
      WAVE_SAW_DN:   sample_d = ~s_val;
      WAVE_TRIANGLE: sample_d = ph1_q[DATA_W] ? ~t_val : t_val;
      WAVE_SINE:     sample_d = ROM_DATA;
      default:       sample_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rom_addr_q <= '0;
      ph1_q      <= '0;
      wave1_q    <= WAVE_SQUARE;
      duty1_q    <= '0;
      vld1_q     <= 1'b0;
      out_q      <= '0;
      vld2_q     <= 1'b0;
    end else if (INIT) begin
      rom_addr_q <= '0;
      ph1_q      <= '0;
      wave1_q    <= WAVE_SQUARE;
      duty1_q    <= '0;
      vld1_q     <= 1'b0;
      out_q      <= '0;
      vld2_q     <= 1'b0;
    end else if (ENB) begin
      rom_addr_q <= phase;
      ph1_q      <= phase[ADDR_W-1 -: DATA_W+1];
      wave1_q    <= act_wave;
      duty1_q    <= act_duty;
      vld1_q     <= 1'b1;
      out_q      <= vld1_q ? sample_d : '0;
      vld2_q     <= vld1_q;
    end
  end

  assign ROM_ADDR   = rom_addr_q;
  assign OUTPUTWAVE = out_q;
  assign VALID      = vld2_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dds_wave_generator : directed self-checking bench for dds_wave_generator
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_dds_wave_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enb = 1'b1;
  logic        init = 1'b0;
  logic        load = 1'b0;
  logic [15:0] freq_word = 16'h0000;
  logic [2:0]  wave_sel = 3'd0;
  logic [7:0]  duty = 8'h80;
  logic        load_ack;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        co;
  logic [7:0]  outputwave;
  logic        valid;

  int checks = 0;
  int errors = 0;

  assign rom_data = rom_addr[9:2];

  always #5 clk = ~clk;

  dds_wave_generator #(
    .ACC_W (16),
    .FREQ_W(16),
    .ADDR_W(10),
    .DATA_W(8)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .ENB       (enb),
    .INIT      (init),
    .FREQ_WORD (freq_word),
    .WAVE_SEL  (wave_sel),
    .DUTY      (duty),
    .LOAD      (load),
    .LOAD_ACK  (load_ack),
    .ROM_ADDR  (rom_addr),
    .ROM_DATA  (rom_data),
    .CO        (co),
    .OUTPUTWAVE(outputwave),
    .VALID     (valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      if (load_ack === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (outputwave !== 8'h00 || valid !== 1'b0 || co !== 1'b0 || load_ack !== 1'b0 || rom_addr !== 10'h000) begin
      errors++;
      $display("FAIL reset_state: got out=%h valid=%b co=%b ack=%b addr=%h expected 00/0/0/0/000",
               outputwave, valid, co, load_ack, rom_addr);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (outputwave !== 8'hFF || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_default_sample: got out=%h valid=%b expected FF/1", outputwave, valid);
    end
  endtask

  task automatic test_saw_up();
    freq_word = 16'h0400; wave_sel = 3'd1; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL saw_ack_early: got %b expected 0", load_ack);
    end
    step();
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL saw_ack: got %b expected 1", load_ack);
    end
    step(); step();
    for (int k = 0; k < 68; k++) begin
      logic [7:0] exp_out;
      logic       exp_co;
      exp_out = 8'(4 * k);
      exp_co  = (k == 62);
      checks++;
      if (outputwave !== exp_out || co !== exp_co || valid !== 1'b1) begin
        errors++;
        $display("FAIL saw_k%0d: got out=%h co=%b valid=%b expected %h/%b/1",
                 k, outputwave, co, valid, exp_out, exp_co);
      end
      step();
    end
  endtask

  task automatic test_square();
    bit ok;
    freq_word = 16'h0400; wave_sel = 3'd0; duty = 8'h40; load = 1'b1;
    step();
    load = 1'b0;
    wait_ack(ok);
    checks++;
    if (!ok || co !== 1'b1) begin
      errors++;
      $display("FAIL square_ack_at_wrap: got ack_seen=%b co=%b expected 1/1", ok, co);
    end
    step(); step();
    for (int k = 0; k < 128; k++) begin
      logic [7:0] d;
      logic [7:0] s;
      logic [7:0] exp_out;
      d = (k < 64) ? 8'h40 : 8'h80;
      s = 8'(4 * k);
      exp_out = (s < d) ? 8'hFF : 8'h00;
      checks++;
      if (outputwave !== exp_out || load_ack !== (k == 62) || co !== ((k % 64) == 62)) begin
        errors++;
        $display("FAIL square_k%0d: got out=%h ack=%b co=%b expected %h/%b/%b",
                 k, outputwave, load_ack, co, exp_out, (k == 62), ((k % 64) == 62));
      end
      if (k == 32) begin
        duty = 8'h80; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_triangle();
    bit ok;
    freq_word = 16'h0400; wave_sel = 3'd3; load = 1'b1;
    step();
    load = 1'b0;
    wait_ack(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tri_ack: got timeout expected ack");
    end
    step(); step();
    for (int k = 0; k < 128; k++) begin
      int j;
      logic [7:0] exp_out;
      j = k % 64;
      exp_out = (j < 32) ? 8'(8 * j) : ~8'(8 * (j - 32));
      checks++;
      if (outputwave !== exp_out) begin
        errors++;
        $display("FAIL tri_k%0d: got %h expected %h", k, outputwave, exp_out);
      end
      step();
    end
  endtask

  task automatic test_sine();
    bit ok;
    freq_word = 16'h0400; wave_sel = 3'd4; load = 1'b1;
    step();
    load = 1'b0;
    wait_ack(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sine_ack: got timeout expected ack");
    end
    step(); step();
    for (int k = 0; k < 16; k++) begin
      logic [9:0] exp_addr;
      logic [7:0] exp_out;
      exp_addr = 10'(16 * (k + 1));
      exp_out  = 8'(4 * k);
      checks++;
      if (rom_addr !== exp_addr || outputwave !== exp_out) begin
        errors++;
        $display("FAIL sine_k%0d: got addr=%h out=%h expected %h/%h",
                 k, rom_addr, outputwave, exp_addr, exp_out);
      end
      step();
    end
  endtask

  task automatic test_pause();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (co === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pause_find_co: got timeout expected CO");
    end
    repeat (10) step();
    checks++;
    if (outputwave !== 8'h20) begin
      errors++;
      $display("FAIL pause_pre: got %h expected 20", outputwave);
    end
    enb = 1'b0; freq_word = 16'h0800; load = 1'b1;
    for (int p = 1; p <= 10; p++) begin
      step();
      load = 1'b0;
      checks++;
      if (outputwave !== 8'h20 || co !== 1'b0 || rom_addr !== 10'h090 || load_ack !== (p == 2)) begin
        errors++;
        $display("FAIL pause_p%0d: got out=%h co=%b addr=%h ack=%b expected 20/0/090/%b",
                 p, outputwave, co, rom_addr, load_ack, (p == 2));
      end
    end
    enb = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      logic [7:0] exp_out;
      step();
      exp_out = (n == 1) ? 8'h24 : 8'(8'h28 + 8 * (n - 2));
      checks++;
      if (outputwave !== exp_out) begin
        errors++;
        $display("FAIL resume_n%0d: got %h expected %h", n, outputwave, exp_out);
      end
    end
  endtask

  task automatic test_init();
    repeat (4) step();
    freq_word = 16'h0400; wave_sel = 3'd1; load = 1'b1;
    step();
    load = 1'b0; init = 1'b1;
    step();
    init = 1'b0;
    checks++;
    if (valid !== 1'b0 || outputwave !== 8'h00 || co !== 1'b0 || rom_addr !== 10'h000 || load_ack !== 1'b1) begin
      errors++;
      $display("FAIL init_clear: got valid=%b out=%h co=%b addr=%h ack=%b expected 0/00/0/000/1",
               valid, outputwave, co, rom_addr, load_ack);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL init_valid_i1: got %b expected 0", valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || outputwave !== 8'h00) begin
      errors++;
      $display("FAIL init_valid_i2: got valid=%b out=%h expected 1/00", valid, outputwave);
    end
    step();
    checks++;
    if (outputwave !== 8'h04) begin
      errors++;
      $display("FAIL init_phase0: got %h expected 04", outputwave);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    freq_word = 16'h0400; wave_sel = 3'd3; load = 1'b1;
    step();
    freq_word = 16'h0800; wave_sel = 3'd1;
    step();
    load = 1'b0;
    wait_ack(ok);
    checks++;
    if (!ok || co !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack: got ack_seen=%b co=%b expected 1/1", ok, co);
    end
    step(); step();
    for (int k = 0; k < 6; k++) begin
      logic [7:0] exp_out;
      exp_out = 8'(8 * k);
      checks++;
      if (outputwave !== exp_out || load_ack !== 1'b0) begin
        errors++;
        $display("FAIL b2b_k%0d: got out=%h ack=%b expected %h/0", k, outputwave, load_ack, exp_out);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    freq_word = 16'h0400; wave_sel = 3'd3; load = 1'b1;
    step();
    load = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outputwave !== 8'h00 || valid !== 1'b0 || co !== 1'b0 || rom_addr !== 10'h000 || load_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got out=%h valid=%b co=%b addr=%h ack=%b expected 00/0/0/000/0",
               outputwave, valid, co, rom_addr, load_ack);
    end
    step(); step();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (load_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard_n%0d: got ack=%b expected 0", n, load_ack);
      end
    end
    checks++;
    if (outputwave !== 8'hFF || valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_default: got out=%h valid=%b expected FF/1", outputwave, valid);
    end
  endtask

  initial begin
    test_reset();
    test_saw_up();
    test_square();
    test_triangle();
    test_sine();
    test_pause();
    test_init();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
